// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

    localparam int PC_W       = 64;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    // Fetch control states: waiting on memory, presenting to decode, stopped at limit.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Branch targets are forced onto an instruction boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, sequential +4 step and aligned redirect load.
// Also keeps the sticky misaligned-redirect flag since it is a property of PC loads.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic            align_err
);

    // Redirect beats the sequential step; the add wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= align_pc(redirect_pc);
        else if (inc)
            pc <= pc + PC_W'(INST_BYTES);
    end

    // Any redirect with nonzero low bits latches the error until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            align_err <= 1'b0;
        else if (redirect && (redirect_pc[1:0] != 2'b00))
            align_err <= 1'b1;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem_addr from the PC, waits RD_LATENCY edges,
// captures the word and hands it to decode over valid/ready. Redirects restart
// fetching at the branch target; reaching PC_LIMIT parks the stage in HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              RD_LATENCY = 1,
    parameter logic [PC_W-1:0] RESET_PC   = 64'h0,
    parameter logic [PC_W-1:0] PC_LIMIT   = 64'h034
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              halted,
    output logic              align_err
);

    // Counter reaches CNT_LAST on the edge that samples memory.
    localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

    fetch_state_t      state;
    logic [2:0]        cnt;
    logic [PC_W-1:0]   pc;
    logic              at_limit;
    logic              pc_inc;

    assign at_limit  = (pc >= PC_LIMIT);
    // The PC only steps on the sampling edge, and never when a redirect lands.
    assign pc_inc    = !redirect && (state == FETCH) && !at_limit && (cnt == CNT_LAST);
    assign imem_addr = pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (CLK),
        .rst         (Reset),
        .inc         (pc_inc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .align_err   (align_err)
    );

    // Fetch FSM with latency counter; redirect overrides any state and any pending handshake.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= FETCH;
            cnt        <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else if (redirect) begin
            state      <= FETCH;
            cnt        <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (at_limit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        inst       <= imem_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= VALID;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                VALID: begin
                    // inst/inst_pc deliberately keep their value after the handshake.
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                HALT: begin
                    halted     <= 1'b1;
                    inst_valid <= 1'b0;
                end
                default: begin
                    state      <= FETCH;
                    cnt        <= '0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances (latency 1, latency 3, wrap-around PC)
// checked every cycle against a behavioural fetch model plus directed checks.
module tb_fetch_unit;

    localparam int N = 3;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] addr [N];
    logic [63:0] ipc  [N];
    logic [63:0] rpc  [N];
    logic [31:0] data [N];
    logic [31:0] inst [N];
    logic        vld  [N];
    logic        rdy  [N];
    logic        redir[N];
    logic        hlt  [N];
    logic        aerr [N];

    int              lat   [N] = '{1, 3, 2};
    longint unsigned lim   [N] = '{64'h34, 64'h34, 64'hFFFF_FFFF_FFFF_FFFF};
    longint unsigned rstpc [N] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC};

    // reference model: PC, edges left until sample, presentation/halt flags
    longint unsigned m_pc  [N];
    longint unsigned m_ipc [N];
    logic [31:0]     m_inst[N];
    int              m_wait[N];
    bit              m_pres[N];
    bit              m_halt[N];
    bit              m_aerr[N];
    int              dut_hs[N];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a == 64'h0) return 32'hF84003E9;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_mem
        assign data[g] = memf(addr[g]);
    end

    fetch_unit #(.RD_LATENCY(1), .RESET_PC(64'h0), .PC_LIMIT(64'h34)) u_d1 (
        .CLK(CLK), .Reset(Reset), .imem_addr(addr[0]), .imem_data(data[0]),
        .inst(inst[0]), .inst_pc(ipc[0]), .inst_valid(vld[0]), .inst_ready(rdy[0]),
        .redirect(redir[0]), .redirect_pc(rpc[0]), .halted(hlt[0]), .align_err(aerr[0]));

    fetch_unit #(.RD_LATENCY(3), .RESET_PC(64'h0), .PC_LIMIT(64'h34)) u_d3 (
        .CLK(CLK), .Reset(Reset), .imem_addr(addr[1]), .imem_data(data[1]),
        .inst(inst[1]), .inst_pc(ipc[1]), .inst_valid(vld[1]), .inst_ready(rdy[1]),
        .redirect(redir[1]), .redirect_pc(rpc[1]), .halted(hlt[1]), .align_err(aerr[1]));

    fetch_unit #(.RD_LATENCY(2), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC),
                 .PC_LIMIT(64'hFFFF_FFFF_FFFF_FFFF)) u_dw (
        .CLK(CLK), .Reset(Reset), .imem_addr(addr[2]), .imem_data(data[2]),
        .inst(inst[2]), .inst_pc(ipc[2]), .inst_valid(vld[2]), .inst_ready(rdy[2]),
        .redirect(redir[2]), .redirect_pc(rpc[2]), .halted(hlt[2]), .align_err(aerr[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_pc[k]   = rstpc[k];
            m_ipc[k]  = 0;
            m_inst[k] = '0;
            m_wait[k] = lat[k];
            m_pres[k] = 0;
            m_halt[k] = 0;
            m_aerr[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            if (redir[k]) begin
                m_pc[k]   = rpc[k] & ~64'h3;
                if (rpc[k][1:0] != 2'b00) m_aerr[k] = 1;
                m_pres[k] = 0;
                m_halt[k] = 0;
                m_wait[k] = lat[k];
            end else if (!m_halt[k]) begin
                if (m_pres[k]) begin
                    if (rdy[k]) begin
                        m_pres[k] = 0;
                        m_wait[k] = lat[k];
                    end
                end else if (m_pc[k] >= lim[k]) begin
                    m_halt[k] = 1;
                end else begin
                    m_wait[k]--;
                    if (m_wait[k] == 0) begin
                        m_inst[k] = memf(m_pc[k]);
                        m_ipc[k]  = m_pc[k];
                        m_pc[k]   = m_pc[k] + 4;
                        m_pres[k] = 1;
                        m_wait[k] = lat[k];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("addr%0d", k),  addr[k], m_pc[k]);
            check($sformatf("valid%0d", k), 64'(vld[k]), 64'(m_pres[k]));
            check($sformatf("halt%0d", k),  64'(hlt[k]), 64'(m_halt[k]));
            check($sformatf("aerr%0d", k),  64'(aerr[k]), 64'(m_aerr[k]));
            check($sformatf("inst%0d", k),  64'(inst[k]), 64'(m_inst[k]));
            check($sformatf("ipc%0d", k),   ipc[k], m_ipc[k]);
        end
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        for (int k = 0; k < N; k++)
            if (vld[k] && rdy[k] && !redir[k]) dut_hs[k]++;
        @(posedge CLK);
        if (Reset) model_reset();
        else model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic wait_vld(input int k, input int budget);
        int n = 0;
        while (!vld[k] && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("wait_valid%0d", k), 64'(vld[k]), 64'h1);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        Reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            rdy[k] = 1'b1; redir[k] = 1'b0; rpc[k] = '0; dut_hs[k] = 0;
        end
        #1;
        model_reset();
        check_all();
        tick(); tick();

        // release; d3 starts with backpressure
        Reset = 1'b0;
        rdy[1] = 1'b0;
        tick();                                   // e1
        check("d1_first_inst", 64'(inst[0]), 64'hF84003E9);
        check("d1_first_pc", ipc[0], 64'h0);
        check("d1_first_vld", 64'(vld[0]), 64'h1);
        check("d1_addr_next", addr[0], 64'h4);
        tick();                                   // e2
        check("dw_first_pc", ipc[2], 64'hFFFF_FFFF_FFFF_FFFC);
        tick();                                   // e3
        check("d3_first_vld", 64'(vld[1]), 64'h1);
        held = inst[1];
        tick(); tick();                           // e5
        check("dw_wrap_pc", ipc[2], 64'h0);
        check("dw_wrap_vld", 64'(vld[2]), 64'h1);
        tick(); tick(); tick();                   // e8: five edges of backpressure
        check("d3_hold_inst", 64'(inst[1]), 64'(held));
        check("d3_hold_pc", ipc[1], 64'h0);
        check("d3_hold_vld", 64'(vld[1]), 64'h1);
        rdy[1] = 1'b1;
        tick();                                   // e9 handshake
        check("d3_drop_vld", 64'(vld[1]), 64'h0);
        tick(); tick();
        check("d3_wait_vld", 64'(vld[1]), 64'h0);
        tick();                                   // e12
        check("d3_next_vld", 64'(vld[1]), 64'h1);
        check("d3_next_pc", ipc[1], 64'h4);
        for (int i = 0; i < 28; i++) begin
            rdy[1] = ($urandom_range(0, 3) != 0);
            rdy[2] = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("d1_count", 64'(dut_hs[0]), 64'd13);
        check("d1_halted", 64'(hlt[0]), 64'h1);
        check("d1_halt_addr", addr[0], 64'h34);
        check("d1_halt_vld", 64'(vld[0]), 64'h0);

        // leave HALT by redirect to 0
        redir[0] = 1'b1; rpc[0] = 64'h0;
        tick();
        redir[0] = 1'b0;
        check("d1_unhalt", 64'(hlt[0]), 64'h0);
        n = 0;
        while (!(vld[0] && ipc[0] == 64'h8) && n < 30) begin tick(); n++; end
        check("d1_reach8", ipc[0], 64'h8);
        // redirect on the handshake edge drops the instruction
        redir[0] = 1'b1; rpc[0] = 64'h1C;
        tick();
        redir[0] = 1'b0;
        check("d1_redir_drop", 64'(vld[0]), 64'h0);
        wait_vld(0, 10);
        check("d1_tgt_pc", ipc[0], 64'h1C);
        tick();
        wait_vld(0, 10);
        check("d1_tgt_next", ipc[0], 64'h20);

        // misaligned target
        redir[0] = 1'b1; rpc[0] = 64'h22;
        tick();
        redir[0] = 1'b0;
        check("d1_aerr_set", 64'(aerr[0]), 64'h1);
        wait_vld(0, 10);
        check("d1_mis_pc", ipc[0], 64'h20);

        // random traffic on all instances
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                rdy[k]   = ($urandom_range(0, 3) != 0);
                redir[k] = ($urandom_range(0, 11) == 0);
                rpc[k]   = 64'($urandom_range(0, 63));
                if (k == 2 && $urandom_range(0, 1) == 1)
                    rpc[k] = {32'hFFFF_FFFF, 26'h3FF_FFFF, 6'($urandom_range(0, 63))};
            end
            tick();
        end
        check("d1_aerr_sticky", 64'(aerr[0]), 64'h1);

        // async reset in the middle of the wrap instance's second wait
        for (int k = 0; k < N; k++) begin rdy[k] = 1'b1; redir[k] = 1'b0; end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick(); tick(); tick(); tick();           // dw: present FC, handshake, one wait edge
        check("dw_in_wait", addr[2], 64'h0);
        #2 Reset = 1'b1;
        #1;
        check("dw_rst_vld", 64'(vld[2]), 64'h0);
        check("dw_rst_addr", addr[2], 64'hFFFF_FFFF_FFFF_FFFC);
        check("dw_rst_ipc", ipc[2], 64'h0);
        check("d1_rst_aerr", 64'(aerr[0]), 64'h0);
        model_reset();
        check_all();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
